// File: rtl/fir4_avg_sink.sv
// Output stage of the 4-tap averaging FIR: rounds the tap sum to a W-bit average,
// discards warm-up windows and queues results in a show-ahead FIFO.
module fir4_avg_sink #(
    parameter int W      = 16,
    parameter int DEPTH  = 8,
    parameter int WARMUP = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [W+1:0]               in_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       primed,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    input  logic                       clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WARMUP + 1);

    // (sum + 2) >>> 2 at W+3 bits; the range of a 4-tap sum keeps the result in W bits.
    function automatic logic [W-1:0] round_avg(input logic [W+1:0] sum);
        logic signed [W+2:0] ext;
        logic signed [W+2:0] shifted;
        ext     = $signed({sum[W+1], sum}) + $signed({{(W+1){1'b0}}, 2'b10});
        shifted = ext >>> 2;
        return shifted[W-1:0];
    endfunction

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic          primed_r;
    logic [CW-1:0] warm_cnt_r;
    logic          overflow_r;
    logic [7:0]    drop_count_r;

    logic          rd_fire_s;
    logic          full_s;
    logic          accept_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [W-1:0]  avg_s;
    logic [LW-1:0] count_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [W-1:0]  head_nxt_s;

    // Handshake decode, next occupancy and the head value visible after this edge.
    always_comb begin
        rd_fire_s    = out_valid_r & out_ready;
        full_s       = (count_r == LW'(DEPTH));
        accept_s     = in_valid & primed_r;
        wr_en_s      = accept_s & (~full_s | rd_fire_s);
        drop_s       = accept_s & full_s & ~rd_fire_s;
        avg_s        = round_avg(in_sum);
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = {W{1'b0}};
        case ({wr_en_s, rd_fire_s})
            2'b10:   count_nxt_s = count_r + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(LW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
        if (rd_fire_s) begin
            rd_ptr_nxt_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // The slot being written this edge is not in mem_r yet, so forward it.
        if (count_nxt_s == {LW{1'b0}}) begin
            head_nxt_s = {W{1'b0}};
        end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = avg_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage; contents need no reset because the head output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[wr_ptr_r] <= avg_s;
        end
    end

    // Pointers, occupancy and registered show-ahead head.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {LW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {LW{1'b0}});
            out_data_r  <= head_nxt_s;
        end
    end

    // Warm-up: the WARMUP-th accepted sample sets primed on its own edge and is still discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt_r <= {CW{1'b0}};
            primed_r   <= 1'b0;
        end else if (in_valid && !primed_r) begin
            warm_cnt_r <= warm_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (warm_cnt_r == CW'(WARMUP - 1)) begin
                primed_r <= 1'b1;
            end
        end
    end

    // Sticky overflow and saturating drop counter; a drop on the clearing edge counts as 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (clear_ovf) begin
                drop_count_r <= 8'd1;
            end else if (drop_count_r != 8'd255) begin
                drop_count_r <= drop_count_r + 8'd1;
            end
        end else if (clear_ovf) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign level      = count_r;
    assign primed     = primed_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule
